addsub_seq: RTL and testbench

Sequential operand-issue and result-capture controller that sits directly upstream and downstream of the 4-bit AddSub4b adder/subtractor. It accepts operation requests over a valid/ready handshake and drives the adder's Ctrl/A/B inputs from registers. It then samples S/Co, derives status flags and holds an internal accumulator. The result is presented on a valid/ready output handshake for the display or register-file stage.

---
 rtl/addsub_pkg.sv | 25 ++
 rtl/addsub_seq_if.sv | 40 ++++
 rtl/addsub_flags.sv | 31 +++
 rtl/addsub_seq.sv | 171 +++++++++++++++++
 tb/tb_addsub_seq.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// Shared opcode constants, FSM state encoding and default datapath width
// for the AddSub4b operand-issue / result-capture controller.
package addsub_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned OP_W      = 3;

    localparam logic [OP_W-1:0] OP_ADD     = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB     = 3'b001;
    localparam logic [OP_W-1:0] OP_ACC_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_ACC_SUB = 3'b011;
    localparam logic [OP_W-1:0] OP_CLR     = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Opcodes 000..011 are the only ones that drive the adder.
    function automatic logic is_adder_op(input logic [OP_W-1:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/addsub_seq_if.sv
// Request, adder-side and result handshake signals of addsub_seq.
// slave is the controller's view; master is the surrounding environment's.
interface addsub_seq_if #(
    parameter int unsigned WIDTH = addsub_pkg::DEF_WIDTH
) ();

    logic                         in_valid;
    logic                         in_ready;
    logic [addsub_pkg::OP_W-1:0]  in_op;
    logic [WIDTH-1:0]             in_a;
    logic [WIDTH-1:0]             in_b;

    logic                         add_ctrl;
    logic [WIDTH-1:0]             add_a;
    logic [WIDTH-1:0]             add_b;
    logic [WIDTH-1:0]             add_s;
    logic                         add_co;

    logic                         out_valid;
    logic                         out_ready;
    logic [WIDTH-1:0]             out_res;
    logic                         out_co;
    logic                         out_zero;
    logic                         out_ov;
    logic                         out_err;
    logic [WIDTH-1:0]             acc;

    modport slave (
        input  in_valid, in_op, in_a, in_b, add_s, add_co, out_ready,
        output in_ready, add_ctrl, add_a, add_b,
        output out_valid, out_res, out_co, out_zero, out_ov, out_err, acc
    );

    modport master (
        output in_valid, in_op, in_a, in_b, add_s, add_co, out_ready,
        input  in_ready, add_ctrl, add_a, add_b,
        input  out_valid, out_res, out_co, out_zero, out_ov, out_err, acc
    );

endinterface

// File: rtl/addsub_flags.sv
// Combinational status flags for one adder result: zero, signed overflow
// (operand signs taken from the issued A/B) and carry pass-through.
module addsub_flags #(
    parameter int unsigned WIDTH = addsub_pkg::DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] s_i,
    input  logic             co_i,
    input  logic             sub_i,
    output logic             zero_c,
    output logic             ov_c,
    output logic             carry_c
);

    logic sign_a;
    logic sign_b;
    logic sign_s;
    logic same_sign;

    assign sign_a    = a_i[WIDTH-1];
    assign sign_b    = b_i[WIDTH-1];
    assign sign_s    = s_i[WIDTH-1];
    assign same_sign = (sign_a == sign_b);

    // Subtraction overflows only when operand signs differ; addition when they match.
    assign ov_c    = (sub_i ? !same_sign : same_sign) && (sign_s != sign_a);
    assign zero_c  = (s_i == '0);
    assign carry_c = co_i;

endmodule

// File: rtl/addsub_seq.sv
// Issues operands to an external AddSub4b, captures S/Co after ADDER_LAT
// extra cycles, maintains an accumulator and presents a held result.
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned ADDER_LAT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    addsub_seq_if.slave bus
);

    localparam int unsigned CNT_W = (ADDER_LAT > 0) ? $clog2(ADDER_LAT + 1) : 1;

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               is_acc_q,    is_acc_d;
    logic               in_ready_q,  in_ready_d;
    logic               add_ctrl_q,  add_ctrl_d;
    logic [WIDTH-1:0]   add_a_q,     add_a_d;
    logic [WIDTH-1:0]   add_b_q,     add_b_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_res_q,   out_res_d;
    logic               out_co_q,    out_co_d;
    logic               out_zero_q,  out_zero_d;
    logic               out_ov_q,    out_ov_d;
    logic               out_err_q,   out_err_d;
    logic [WIDTH-1:0]   acc_q,       acc_d;

    logic               flag_zero_c;
    logic               flag_ov_c;
    logic               flag_carry_c;

    // Flags are evaluated against the operands actually issued to the adder.
    addsub_flags #(
        .WIDTH (WIDTH)
    ) u_flags (
        .a_i     (add_a_q),
        .b_i     (add_b_q),
        .s_i     (bus.add_s),
        .co_i    (bus.add_co),
        .sub_i   (add_ctrl_q),
        .zero_c  (flag_zero_c),
        .ov_c    (flag_ov_c),
        .carry_c (flag_carry_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_acc_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            add_ctrl_q  <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_co_q    <= 1'b0;
            out_zero_q  <= 1'b0;
            out_ov_q    <= 1'b0;
            out_err_q   <= 1'b0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_acc_q    <= is_acc_d;
            in_ready_q  <= in_ready_d;
            add_ctrl_q  <= add_ctrl_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_co_q    <= out_co_d;
            out_zero_q  <= out_zero_d;
            out_ov_q    <= out_ov_d;
            out_err_q   <= out_err_d;
            acc_q       <= acc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_acc_d    = is_acc_q;
        add_ctrl_d  = add_ctrl_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        out_co_d    = out_co_q;
        out_zero_d  = out_zero_q;
        out_ov_d    = out_ov_q;
        out_err_d   = out_err_q;
        acc_d       = acc_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (is_adder_op(bus.in_op)) begin
                        add_a_d    = bus.in_op[1] ? acc_q : bus.in_a;
                        add_b_d    = bus.in_b;
                        add_ctrl_d = bus.in_op[0];
                        is_acc_d   = bus.in_op[1];
                        cnt_d      = CNT_W'(ADDER_LAT);
                        state_d    = EXEC;
                    end else if (bus.in_op == OP_CLR) begin
                        out_res_d   = '0;
                        out_zero_d  = 1'b1;
                        out_co_d    = 1'b0;
                        out_ov_d    = 1'b0;
                        out_err_d   = 1'b0;
                        acc_d       = '0;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        // Illegal opcode reports the untouched accumulator.
                        out_res_d   = acc_q;
                        out_zero_d  = (acc_q == '0);
                        out_co_d    = 1'b0;
                        out_ov_d    = 1'b0;
                        out_err_d   = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    out_res_d   = bus.add_s;
                    out_co_d    = flag_carry_c;
                    out_zero_d  = flag_zero_c;
                    out_ov_d    = flag_ov_c;
                    out_err_d   = 1'b0;
                    if (is_acc_q) begin
                        acc_d = bus.add_s;
                    end
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.add_ctrl  = add_ctrl_q;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_res   = out_res_q;
    assign bus.out_co    = out_co_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_ov    = out_ov_q;
    assign bus.out_err   = out_err_q;
    assign bus.acc       = acc_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq: two instances (ADDER_LAT 0 and 2), each
// wired to a behavioural 4-bit add/subtract stage standing in for AddSub4b.
module tb_addsub_seq;
    import addsub_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   n;

    addsub_seq_if #(.WIDTH(4)) if0 ();
    addsub_seq_if #(.WIDTH(4)) if2 ();

    // Subtraction as A + ~B + 1 so Co=1 means no borrow.
    assign {if0.add_co, if0.add_s} = if0.add_ctrl ?
        ({1'b0, if0.add_a} + {1'b0, ~if0.add_b} + 5'd1) : ({1'b0, if0.add_a} + {1'b0, if0.add_b});
    assign {if2.add_co, if2.add_s} = if2.add_ctrl ?
        ({1'b0, if2.add_a} + {1'b0, ~if2.add_b} + 5'd1) : ({1'b0, if2.add_a} + {1'b0, if2.add_b});

    addsub_seq #(.WIDTH(4), .ADDER_LAT(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    addsub_seq #(.WIDTH(4), .ADDER_LAT(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send0(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        if0.in_valid = 1'b1; if0.in_op = op; if0.in_a = a; if0.in_b = b;
        tick();
        if0.in_valid = 1'b0;
    endtask

    task automatic send2(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        if2.in_valid = 1'b1; if2.in_op = op; if2.in_a = a; if2.in_b = b;
        tick();
        if2.in_valid = 1'b0;
    endtask

    // Edges until out_valid, capped at 20 (a cap never matches an expected latency).
    task automatic wait0(output int cnt);
        cnt = 0;
        while (if0.out_valid !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    endtask

    task automatic wait2(output int cnt);
        cnt = 0;
        while (if2.out_valid !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    endtask

    task automatic drain0();
        if0.out_ready = 1'b1; tick(); if0.out_ready = 1'b0;
    endtask

    task automatic drain2();
        if2.out_ready = 1'b1; tick(); if2.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_tests++;
        if ({if0.out_valid, if0.out_res, if0.out_co, if0.out_zero, if0.out_ov, if0.out_err,
             if0.acc, if0.add_ctrl, if0.add_a, if0.add_b} !== 22'd0) begin
            n_fail++; $display("FAIL reset0: outputs not all zero (acc=%0d res=%0d)", if0.acc, if0.out_res);
        end
        n_tests++;
        if ({if2.out_valid, if2.out_res, if2.acc, if2.add_ctrl, if2.add_a, if2.add_b} !== 18'd0) begin
            n_fail++; $display("FAIL reset2: outputs not all zero (acc=%0d res=%0d)", if2.acc, if2.out_res);
        end
        rst_n = 1'b1;
        tick();
        n_tests++;
        if ({if0.in_ready, if2.in_ready} !== 2'b11) begin
            n_fail++; $display("FAIL reset_ready: got %b want 11", {if0.in_ready, if2.in_ready});
        end
    endtask

    task automatic test_add();
        send0(OP_ADD, 4'b0010, 4'b0001);
        n_tests++;
        if ({if0.add_ctrl, if0.add_a, if0.add_b} !== 9'b0_0010_0001) begin
            n_fail++; $display("FAIL add_issue: got %b want 000100001", {if0.add_ctrl, if0.add_a, if0.add_b});
        end
        wait0(n);
        n_tests++;
        if (n !== 1) begin n_fail++; $display("FAIL add_latency: got %0d want 1", n); end
        n_tests++;
        if ({if0.out_res, if0.out_co, if0.out_zero, if0.out_ov, if0.out_err} !== 8'b0011_0000) begin
            n_fail++; $display("FAIL add_result: got %b want 00110000",
                               {if0.out_res, if0.out_co, if0.out_zero, if0.out_ov, if0.out_err});
        end
        drain0();
        n_tests++;
        if ({if0.out_valid, if0.in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL add_drain: valid/ready got %b want 01", {if0.out_valid, if0.in_ready});
        end
    endtask

    task automatic test_sub();
        send0(OP_SUB, 4'b1100, 4'b1011);
        n_tests++;
        if (if0.add_ctrl !== 1'b1) begin n_fail++; $display("FAIL sub_ctrl: got %b want 1", if0.add_ctrl); end
        wait0(n);
        n_tests++;
        if ({if0.out_res, if0.out_co, if0.out_zero, if0.out_ov, if0.out_err} !== 8'b0001_1000 || n !== 1) begin
            n_fail++; $display("FAIL sub_result: got %b lat %0d want 00011000 lat 1",
                               {if0.out_res, if0.out_co, if0.out_zero, if0.out_ov, if0.out_err}, n);
        end
        drain0();
    endtask

    task automatic test_accumulate();
        send0(OP_CLR, 4'hF, 4'hF);
        wait0(n);
        n_tests++;
        if ({if0.out_res, if0.out_co, if0.out_zero, if0.out_ov, if0.out_err, if0.acc} !== 12'b0000_0100_0000 || n !== 0) begin
            n_fail++; $display("FAIL clr: got %b lat %0d want 000001000000 lat 0",
                               {if0.out_res, if0.out_co, if0.out_zero, if0.out_ov, if0.out_err, if0.acc}, n);
        end
        drain0();
        send0(OP_ACC_ADD, 4'hF, 4'd7);
        wait0(n);
        n_tests++;
        if ({if0.out_res, if0.out_co, if0.out_zero, if0.out_ov, if0.out_err, if0.acc} !== 12'b0111_0000_0111) begin
            n_fail++; $display("FAIL acc_add7: got %b want 011100000111",
                               {if0.out_res, if0.out_co, if0.out_zero, if0.out_ov, if0.out_err, if0.acc});
        end
        drain0();
        send0(OP_ACC_ADD, 4'h0, 4'd1);
        wait0(n);
        n_tests++;
        if ({if0.out_res, if0.out_co, if0.out_zero, if0.out_ov, if0.out_err, if0.acc} !== 12'b1000_0010_1000) begin
            n_fail++; $display("FAIL acc_add1_ov: got %b want 100000101000",
                               {if0.out_res, if0.out_co, if0.out_zero, if0.out_ov, if0.out_err, if0.acc});
        end
        drain0();
        send0(OP_ACC_SUB, 4'h0, 4'd8);
        wait0(n);
        n_tests++;
        if ({if0.out_res, if0.out_co, if0.out_zero, if0.out_ov, if0.out_err, if0.acc} !== 12'b0000_1100_0000) begin
            n_fail++; $display("FAIL acc_sub8: got %b want 000011000000",
                               {if0.out_res, if0.out_co, if0.out_zero, if0.out_ov, if0.out_err, if0.acc});
        end
        drain0();
    endtask

    task automatic test_backpressure();
        send0(OP_ADD, 4'd3, 4'd4);
        wait0(n);
        if0.in_valid = 1'b1; if0.in_op = OP_ADD; if0.in_a = 4'd1; if0.in_b = 4'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if ({if0.out_valid, if0.in_ready, if0.out_res, if0.out_co, if0.out_zero, if0.out_ov, if0.out_err} !== 10'b10_0111_0000) begin
                n_fail++; $display("FAIL bp_hold cycle %0d: got %b want 1001110000", i,
                    {if0.out_valid, if0.in_ready, if0.out_res, if0.out_co, if0.out_zero, if0.out_ov, if0.out_err});
            end
        end
        drain0();
        n_tests++;
        if ({if0.out_valid, if0.in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL bp_release: valid/ready got %b want 01", {if0.out_valid, if0.in_ready});
        end
        tick();
        if0.in_valid = 1'b0;
        n_tests++;
        if ({if0.in_ready, if0.add_a, if0.add_b} !== 9'b0_0001_0001) begin
            n_fail++; $display("FAIL bp_accept: got %b want 000010001", {if0.in_ready, if0.add_a, if0.add_b});
        end
        wait0(n);
        n_tests++;
        if (if0.out_res !== 4'd2 || n !== 1) begin
            n_fail++; $display("FAIL bp_second: res %0d lat %0d want res 2 lat 1", if0.out_res, n);
        end
        drain0();
    endtask

    task automatic test_latency_reset();
        logic stray;
        send2(OP_ADD, 4'd5, 4'd6);
        wait2(n);
        n_tests++;
        if (n !== 3) begin n_fail++; $display("FAIL lat2_latency: got %0d want 3", n); end
        n_tests++;
        if ({if2.out_res, if2.out_co, if2.out_zero, if2.out_ov, if2.out_err} !== 8'b1011_0010) begin
            n_fail++; $display("FAIL lat2_result: got %b want 10110010",
                               {if2.out_res, if2.out_co, if2.out_zero, if2.out_ov, if2.out_err});
        end
        drain2();
        send2(OP_ACC_ADD, 4'd0, 4'd6);
        wait2(n);
        n_tests++;
        if (if2.acc !== 4'd6 || n !== 3) begin
            n_fail++; $display("FAIL lat2_acc: acc %0d lat %0d want acc 6 lat 3", if2.acc, n);
        end
        drain2();
        send2(OP_ADD, 4'd5, 4'd6);
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({if2.out_valid, if2.acc, if2.out_res, if2.add_a, if2.add_b, if2.add_ctrl} !== 18'd0) begin
            n_fail++; $display("FAIL midreset: acc %0d res %0d a %0d valid %b want all 0",
                               if2.acc, if2.out_res, if2.add_a, if2.out_valid);
        end
        #2 rst_n = 1'b1;
        tick();
        n_tests++;
        if (if2.in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b want 1", if2.in_ready); end
        stray = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (if2.out_valid !== 1'b0) stray = 1'b1;
        end
        n_tests++;
        if (stray !== 1'b0) begin n_fail++; $display("FAIL midreset_stray: got out_valid after reset, want none"); end
    endtask

    task automatic test_illegal();
        send0(OP_CLR, 4'd0, 4'd0);
        wait0(n);
        drain0();
        send0(OP_ACC_ADD, 4'd0, 4'd3);
        wait0(n);
        drain0();
        n_tests++;
        if (if0.acc !== 4'd3) begin n_fail++; $display("FAIL ill_setup: acc %0d want 3", if0.acc); end
        send0(3'b111, 4'd9, 4'd9);
        wait0(n);
        n_tests++;
        if ({if0.out_res, if0.out_co, if0.out_zero, if0.out_ov, if0.out_err, if0.acc} !== 12'b0011_0001_0011 || n !== 0) begin
            n_fail++; $display("FAIL illegal: got %b lat %0d want 001100010011 lat 0",
                               {if0.out_res, if0.out_co, if0.out_zero, if0.out_ov, if0.out_err, if0.acc}, n);
        end
        drain0();
        send0(OP_ADD, 4'd1, 4'd1);
        wait0(n);
        n_tests++;
        if ({if0.out_res, if0.out_co, if0.out_zero, if0.out_ov, if0.out_err, if0.acc} !== 12'b0010_0000_0011) begin
            n_fail++; $display("FAIL ill_recover: got %b want 001000000011",
                               {if0.out_res, if0.out_co, if0.out_zero, if0.out_ov, if0.out_err, if0.acc});
        end
        drain0();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        if0.in_valid = 1'b0; if0.in_op = 3'd0; if0.in_a = 4'd0; if0.in_b = 4'd0; if0.out_ready = 1'b0;
        if2.in_valid = 1'b0; if2.in_op = 3'd0; if2.in_a = 4'd0; if2.in_b = 4'd0; if2.out_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_accumulate();
        test_backpressure();
        test_latency_reset();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
